// File: rtl/cadss_ic_pkg.sv
// -----------------------------------------------------------------------------
// cadss_ic_pkg
//   Shared types and default sizing for the CADSS interconnect transfer engine.
//   - DEF_*      : default parameter values used by ic_xfer_scheduler
//   - ch_state_e : per-channel transfer state
//   - xfer_t     : transfer record {brt, addr, src, dest} at the default widths
//                  (the scheduler builds an identically ordered record at its
//                  own parameterised widths)
// -----------------------------------------------------------------------------
package cadss_ic_pkg;

    localparam int unsigned DEF_NUM_PROCS  = 4;
    localparam int unsigned DEF_ADDR_W     = 64;
    localparam int unsigned DEF_BRT_W      = 3;
    localparam int unsigned DEF_FIFO_DEPTH = 8;
    localparam int unsigned DEF_NUM_CH     = 2;
    localparam int unsigned DEF_LATENCY    = 400;
    localparam int unsigned DEF_PROC_W     = (DEF_NUM_PROCS > 1) ? $clog2(DEF_NUM_PROCS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } ch_state_e;

    typedef struct packed {
        logic [DEF_BRT_W-1:0]  brt;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_PROC_W-1:0] src;
        logic [DEF_PROC_W-1:0] dest;
    } xfer_t;

endpackage

// File: rtl/ic_xfer_channel.sv
// -----------------------------------------------------------------------------
// ic_xfer_channel
//   One transfer channel: holds a transfer record, counts LATENCY cycles, then
//   waits in DONE until the completion port retires it.
// Ports
//   clk, rst_l     clock, asynchronous active-low reset
//   load_i         dispatch this cycle (only honoured in IDLE)
//   xfer_i         transfer record to capture on load
//   retire_i       completion handshake for this channel (only honoured in DONE)
//   match_addr_i   address to compare for the same-address hazard check
//   state_o        current state
//   cnt_o          remaining count (meaningful in COUNT, 0 otherwise)
//   xfer_o         stored transfer record
//   match_o        channel busy (COUNT/DONE) with stored addr == match_addr_i
// -----------------------------------------------------------------------------
module ic_xfer_channel
    import cadss_ic_pkg::*;
#(
    parameter int unsigned XFER_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned ADDR_LSB = 0,
    parameter int unsigned LATENCY  = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              load_i,
    input  logic [XFER_W-1:0] xfer_i,
    input  logic              retire_i,
    input  logic [ADDR_W-1:0] match_addr_i,
    output ch_state_e         state_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [XFER_W-1:0] xfer_o,
    output logic              match_o
);

    ch_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XFER_W-1:0] xfer_q, xfer_d;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xfer_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xfer_q  <= xfer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xfer_d  = xfer_q;
        unique case (state_q)
            IDLE: begin
                if (load_i) begin
                    state_d = COUNT;
                    cnt_d   = CNT_W'(LATENCY);
                    xfer_d  = xfer_i;
                end
            end
            COUNT: begin
                // Count reaches 0 as the channel enters DONE, so DONE never
                // contributes a stale count.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (retire_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        state_o = state_q;
        cnt_o   = cnt_q;
        xfer_o  = xfer_q;
        match_o = (state_q != IDLE) && (xfer_q[ADDR_LSB +: ADDR_W] == match_addr_i);
    end

endmodule

// File: rtl/ic_xfer_scheduler.sv
// -----------------------------------------------------------------------------
// ic_xfer_scheduler
//   Cache-transfer engine for the CADSS bus interconnect. Requests are queued
//   in an in-order FIFO, dispatched (one per cycle) to the lowest free channel
//   unless a busy channel already holds the head's address, counted down for
//   LATENCY cycles, and retired through a round-robin valid/ready port.
// Ports
//   clk, rst_l                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready = FIFO not full)
//   req_brt/addr/src/dest      request fields
//   req_err                    1-cycle pulse after a src==dest request
//   cmpl_valid/cmpl_ready      completion handshake
//   cmpl_brt/addr/src/dest     completed transfer fields
//   busy                       FIFO non-empty or any channel active
//   countdown                  minimum remaining count over counting channels
// -----------------------------------------------------------------------------
module ic_xfer_scheduler
    import cadss_ic_pkg::*;
#(
    parameter int unsigned NUM_PROCS  = DEF_NUM_PROCS,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned BRT_W      = DEF_BRT_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned LATENCY    = DEF_LATENCY,
    localparam int unsigned PROC_W    = (NUM_PROCS > 1) ? $clog2(NUM_PROCS) : 1,
    localparam int unsigned CNT_W     = $clog2(LATENCY + 1)
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [BRT_W-1:0]  req_brt,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [PROC_W-1:0] req_src,
    input  logic [PROC_W-1:0] req_dest,
    output logic              req_err,
    output logic              cmpl_valid,
    input  logic              cmpl_ready,
    output logic [BRT_W-1:0]  cmpl_brt,
    output logic [ADDR_W-1:0] cmpl_addr,
    output logic [PROC_W-1:0] cmpl_src,
    output logic [PROC_W-1:0] cmpl_dest,
    output logic              busy,
    output logic [CNT_W-1:0]  countdown
);

    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned XFER_W   = BRT_W + ADDR_W + 2 * PROC_W;
    localparam int unsigned ADDR_LSB = 2 * PROC_W;

    typedef struct packed {
        logic [BRT_W-1:0]  brt;
        logic [ADDR_W-1:0] addr;
        logic [PROC_W-1:0] src;
        logic [PROC_W-1:0] dest;
    } xfer_p_t;

    // ---------------- request FIFO ----------------
    xfer_p_t          fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, full_d;
    logic             err_q, err_d;

    xfer_p_t req_x;
    xfer_p_t head;
    logic    req_hs;
    logic    push;
    logic    pop;

    // ---------------- channels ----------------
    ch_state_e         ch_state [NUM_CH];
    logic [CNT_W-1:0]  ch_cnt   [NUM_CH];
    logic [XFER_W-1:0] ch_xfer  [NUM_CH];
    logic [NUM_CH-1:0] ch_match;
    logic [NUM_CH-1:0] ch_load;
    logic [NUM_CH-1:0] ch_retire;

    logic              idle_found;
    logic [CH_W-1:0]   disp_ch;
    logic              any_active;

    // ---------------- completion arbiter ----------------
    logic [CH_W-1:0]   rr_q, rr_d;
    logic              lock_q, lock_d;
    logic [CH_W-1:0]   lock_gnt_q, lock_gnt_d;
    logic              rr_found;
    logic [CH_W-1:0]   rr_gnt;
    logic [CH_W-1:0]   gnt;
    logic              cmpl_hs;
    xfer_p_t           cmpl_x;

    logic              min_found;
    logic [CNT_W-1:0]  min_cnt;

    // Request side
    always_comb begin
        req_x     = '{brt: req_brt, addr: req_addr, src: req_src, dest: req_dest};
        req_ready = rst_l & ~full_q;
        req_hs    = req_valid & req_ready;
        push      = req_hs & (req_src != req_dest);
        err_d     = req_hs & (req_src == req_dest);
        head      = fifo_q[rd_ptr_q];
    end

    // Lowest-index idle channel, and activity summary
    always_comb begin
        idle_found = 1'b0;
        disp_ch    = '0;
        any_active = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_state[CH_W'(i)] != IDLE) begin
                any_active = 1'b1;
            end else if (!idle_found) begin
                idle_found = 1'b1;
                disp_ch    = CH_W'(i);
            end
        end
    end

    // The head stalls in place while any active channel holds its address.
    assign pop = (count_q != '0) & idle_found & ~(|ch_match);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        full_d   = (count_d == (PTR_W+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= req_x;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_gnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            err_q      <= err_d;
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_gnt_q <= lock_gnt_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_load[g]   = pop && (disp_ch == CH_W'(g));
        assign ch_retire[g] = cmpl_hs && (gnt == CH_W'(g));

        ic_xfer_channel #(
            .XFER_W   (XFER_W),
            .ADDR_W   (ADDR_W),
            .ADDR_LSB (ADDR_LSB),
            .LATENCY  (LATENCY),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk          (clk),
            .rst_l        (rst_l),
            .load_i       (ch_load[g]),
            .xfer_i       (head),
            .retire_i     (ch_retire[g]),
            .match_addr_i (head.addr),
            .state_o      (ch_state[g]),
            .cnt_o        (ch_cnt[g]),
            .xfer_o       (ch_xfer[g]),
            .match_o      (ch_match[g])
        );
    end

    // Round-robin search over DONE channels starting at rr_q
    always_comb begin
        int unsigned idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_gnt   = rr_q;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_q) + k) % NUM_CH;
            if (!rr_found && ch_state[CH_W'(idx)] == DONE) begin
                rr_found = 1'b1;
                rr_gnt   = CH_W'(idx);
            end
        end
    end

    // Once presented, a grant is frozen until its handshake: a channel reaching
    // DONE later but earlier in RR order must not steal the port mid-stall.
    always_comb begin
        gnt        = lock_q ? lock_gnt_q : rr_gnt;
        cmpl_valid = lock_q | rr_found;
        cmpl_hs    = cmpl_valid & cmpl_ready;
        lock_d     = cmpl_valid & ~cmpl_ready;
        lock_gnt_d = gnt;
        rr_d       = rr_q;
        if (cmpl_hs) begin
            rr_d = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);
        end
        cmpl_x = cmpl_valid ? xfer_p_t'(ch_xfer[gnt]) : '0;
    end

    // Minimum remaining count across COUNT channels
    always_comb begin
        min_found = 1'b0;
        min_cnt   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_state[CH_W'(i)] == COUNT &&
                (!min_found || ch_cnt[CH_W'(i)] < min_cnt)) begin
                min_found = 1'b1;
                min_cnt   = ch_cnt[CH_W'(i)];
            end
        end
    end

    always_comb begin
        req_err   = err_q;
        cmpl_brt  = cmpl_x.brt;
        cmpl_addr = cmpl_x.addr;
        cmpl_src  = cmpl_x.src;
        cmpl_dest = cmpl_x.dest;
        busy      = (count_q != '0) | any_active;
        countdown = min_cnt;
    end

endmodule

// File: tb/tb_ic_xfer_scheduler.sv
module tb_ic_xfer_scheduler;
    import cadss_ic_pkg::*;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_brt = '0;
    logic [63:0] req_addr = '0;
    logic [1:0]  req_src = '0;
    logic [1:0]  req_dest = '0;
    logic        req_err;
    logic        cmpl_valid;
    logic        cmpl_ready = 1'b0;
    logic [2:0]  cmpl_brt;
    logic [63:0] cmpl_addr;
    logic [1:0]  cmpl_src;
    logic [1:0]  cmpl_dest;
    logic        busy;
    logic [2:0]  countdown;

    ic_xfer_scheduler #(
        .NUM_PROCS  (4),
        .ADDR_W     (64),
        .BRT_W      (3),
        .FIFO_DEPTH (8),
        .NUM_CH     (2),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_brt    (req_brt),
        .req_addr   (req_addr),
        .req_src    (req_src),
        .req_dest   (req_dest),
        .req_err    (req_err),
        .cmpl_valid (cmpl_valid),
        .cmpl_ready (cmpl_ready),
        .cmpl_brt   (cmpl_brt),
        .cmpl_addr  (cmpl_addr),
        .cmpl_src   (cmpl_src),
        .cmpl_dest  (cmpl_dest),
        .busy       (busy),
        .countdown  (countdown)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    xfer_t       sb_q[$];
    xfer_t       comp_q[$];
    int unsigned comp_cyc_q[$];

    logic  prev_hold = 1'b0;
    xfer_t prev_x;

    always @(negedge clk) begin : mon
        xfer_t cx;
        int    found;
        cx    = '{brt: cmpl_brt, addr: cmpl_addr, src: cmpl_src, dest: cmpl_dest};
        found = -1;
        if (!rst_l) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", cmpl_valid, 1'b1);
                chk("hold_fields", cx, prev_x);
            end
            if (cmpl_valid && cmpl_ready) begin
                for (int i = 0; i < sb_q.size(); i++)
                    if (found < 0 && sb_q[i].addr == cx.addr) found = i;
                if (found < 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL cmpl_unexpected: got addr 0x%0h, expected a pending transfer", cx.addr);
                end else begin
                    chk("cmpl_fields", cx, sb_q[found]);
                    sb_q.delete(found);
                end
                comp_q.push_back(cx);
                comp_cyc_q.push_back(cyc);
            end
            prev_hold = cmpl_valid && !cmpl_ready;
            prev_x    = cx;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        v;
        logic [2:0]  brt;
        logic [63:0] addr;
        logic [1:0]  src;
        logic [1:0]  dest;
        logic        crdy;
        logic        e_valid;
        logic [63:0] e_addr;
        logic [2:0]  e_cd;
        logic        e_busy;
        logic        e_ready;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [2:0] brt, logic [63:0] addr, logic [1:0] src,
                                logic [1:0] dest, logic crdy, logic ev, logic [63:0] ea,
                                logic [2:0] ecd, logic eb, logic er);
        vec_t r;
        r = '{v, brt, addr, src, dest, crdy, ev, ea, ecd, eb, er};
        return r;
    endfunction

    task automatic drive(input logic v, input logic [2:0] brt, input logic [63:0] addr,
                         input logic [1:0] src, input logic [1:0] dest);
        req_valid = v;
        req_brt   = brt;
        req_addr  = addr;
        req_src   = src;
        req_dest  = dest;
        if (v && req_ready && src != dest)
            sb_q.push_back('{brt: brt, addr: addr, src: src, dest: dest});
    endtask

    task automatic apply(input vec_t r);
        cmpl_ready = r.crdy;
        drive(r.v, r.brt, r.addr, r.src, r.dest);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1'b0);
        chk({tag, "_req_err"}, req_err, 1'b0);
        chk({tag, "_cmpl_valid"}, cmpl_valid, 1'b0);
        chk({tag, "_cmpl_addr"}, cmpl_addr, 64'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_countdown"}, countdown, 3'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned base;
        int unsigned t;
        int unsigned acc;
        int unsigned c;

        // Test 1: single transfer, LATENCY=4
        tbl.push_back(mk(1, 3'd1, 64'h40, 2'd0, 2'd1, 1, 0, 0,      3'd0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,               1, 0, 0,      3'd4, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,               1, 0, 0,      3'd3, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,               1, 0, 0,      3'd2, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,               1, 0, 0,      3'd1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,               1, 1, 64'h40, 3'd0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,               1, 0, 0,      3'd0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,               1, 0, 0,      3'd0, 0, 1));
        // Test 2: three back-to-back requests, two channels overlap
        tbl.push_back(mk(1, 3'd2, 64'h100, 2'd1, 2'd2, 1, 0, 0,       3'd0, 1, 1));
        tbl.push_back(mk(1, 3'd5, 64'h140, 2'd3, 2'd0, 1, 0, 0,       3'd4, 1, 1));
        tbl.push_back(mk(1, 3'd7, 64'h180, 2'd2, 2'd1, 1, 0, 0,       3'd3, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, 0, 0,       3'd2, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, 0, 0,       3'd1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, 1, 64'h100, 3'd1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, 1, 64'h140, 3'd0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, 0, 0,       3'd4, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, 0, 0,       3'd3, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, 0, 0,       3'd2, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, 0, 0,       3'd1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, 1, 64'h180, 3'd0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, 0, 0,       3'd0, 0, 1));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst_l = 1'b1;

        // Table-driven run: row i inputs precede edge i, outputs checked after it
        @(posedge clk); #1;
        apply(tbl[0]);
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            if (i + 1 < tbl.size()) apply(tbl[i + 1]);
            else drive(0, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("row%0d_cmpl_valid", i), cmpl_valid, tbl[i].e_valid);
            chk($sformatf("row%0d_countdown", i), countdown, tbl[i].e_cd);
            chk($sformatf("row%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("row%0d_req_ready", i), req_ready, tbl[i].e_ready);
            if (tbl[i].e_valid) chk($sformatf("row%0d_cmpl_addr", i), cmpl_addr, tbl[i].e_addr);
        end

        // Test 3: same-address hazard with in-order blocking
        @(posedge clk); #1;
        cmpl_ready = 1'b1;
        c    = cyc;
        base = comp_q.size();
        drive(1, 3'd3, 64'h80, 2'd0, 2'd3);
        @(posedge clk); #1;
        drive(1, 3'd4, 64'h80, 2'd1, 2'd3);
        @(posedge clk); #1;
        drive(1, 3'd6, 64'hC0, 2'd2, 2'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        t = 0;
        while (comp_q.size() < base + 3 && t < 40) begin
            @(posedge clk); t++;
        end
        #1;
        chk("t3_completions", comp_q.size(), base + 3);
        if (comp_q.size() >= base + 3) begin
            chk("t3_first_addr", comp_q[base].addr, 64'h80);
            chk("t3_first_cyc", comp_cyc_q[base], c + 6);
            chk("t3_second_cyc", comp_cyc_q[base + 1], c + 12);
            chk("t3_third_addr", comp_q[base + 2].addr, 64'hC0);
            chk("t3_third_cyc", comp_cyc_q[base + 2], c + 13);
        end

        // Test 4: backpressure fill, stable hold, round-robin release
        @(posedge clk); #1;
        cmpl_ready = 1'b0;
        acc = 0;
        t   = 0;
        while (acc < 10 && t < 40) begin
            if (req_ready) begin
                drive(1, 3'(acc), 64'h1000 + 64'(acc) * 64'h40, 2'(acc), 2'(acc + 1));
                acc++;
            end else begin
                drive(0, 0, 0, 0, 0);
            end
            @(posedge clk); #1; t++;
        end
        drive(0, 0, 0, 0, 0);
        chk("t4_accepted", acc, 10);
        @(negedge clk);
        chk("t4_full_ready", req_ready, 1'b0);
        chk("t4_busy", busy, 1'b1);
        repeat (6) @(negedge clk);
        chk("t4_valid_held", cmpl_valid, 1'b1);
        chk("t4_first_addr", cmpl_addr, 64'h1000);
        chk("t4_still_full", req_ready, 1'b0);
        @(posedge clk); #1;
        base = comp_q.size();
        cmpl_ready = 1'b1;
        t = 0;
        while (comp_q.size() < base + 10 && t < 200) begin
            @(posedge clk); t++;
        end
        #1;
        chk("t4_drained", comp_q.size(), base + 10);
        if (comp_q.size() >= base + 3) begin
            chk("t4_rr_ch0", comp_q[base].addr, 64'h1000);
            chk("t4_rr_ch1", comp_q[base + 1].addr, 64'h1040);
            chk("t4_rr_ch1_gap", comp_cyc_q[base + 1] - comp_cyc_q[base], 1);
            chk("t4_rr_ch0_again", comp_q[base + 2].addr, 64'h1080);
        end
        repeat (2) @(negedge clk);
        chk("t4_idle_busy", busy, 1'b0);

        // Test 5: src == dest rejected
        @(posedge clk); #1;
        base = comp_q.size();
        drive(1, 3'd1, 64'h200, 2'd2, 2'd2);
        @(negedge clk);
        chk("t5_err_before", req_err, 1'b0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_err_pulse", req_err, 1'b1);
        chk("t5_busy", busy, 1'b0);
        @(negedge clk);
        chk("t5_err_clear", req_err, 1'b0);
        chk("t5_busy_after", busy, 1'b0);
        repeat (LAT + 3) @(negedge clk);
        chk("t5_no_cmpl", comp_q.size(), base);

        // Test 6: asynchronous reset mid-COUNT
        @(posedge clk); #1;
        drive(1, 3'd5, 64'hDEAD00, 2'd1, 2'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk); #3;
        chk("t6_counting", countdown, 3'd3);
        rst_l = 1'b0;
        #1;
        check_zero("t6_async");
        sb_q.delete();
        base = comp_q.size();
        @(posedge clk); @(posedge clk); #1;
        rst_l = 1'b1;
        repeat (LAT + 6) @(negedge clk);
        chk("t6_no_cmpl", comp_q.size(), base);
        chk("t6_busy", busy, 1'b0);
        chk("t6_ready", req_ready, 1'b1);

        chk("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
